// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC source encodings and the PC sequencer
// state type, imported by the PC sequencer and its next-PC mux.
package cpu_pkg;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_REG    = 2'b10;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b11;

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } pc_state_t;

  // True when the low two address bits are clear.
  function automatic logic isWordAligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selector: sequential, branch, register jump and
// immediate jump. Also reports a raw misalign bit for a register jump
// whose target is not word aligned; the caller decides whether it counts.
module pc_next_mux
  import cpu_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_pcSrc,
  input  logic [31:0] i_immExt,
  input  logic [31:0] i_regJumpAddr,
  input  logic [31:0] i_jumpAddr,
  output logic [31:0] o_nextPc,
  output logic        o_misalignRaw
);

  logic [31:0] w_pcPlus4;
  logic [31:0] w_branchOffset;

  assign w_pcPlus4      = i_pc + 32'd4;
  // Word offset to byte offset; the two bits shifted out are dropped.
  assign w_branchOffset = i_immExt << 2;

  // Pick the next PC from the selected source; arithmetic wraps silently.
  always_comb begin
    o_nextPc      = w_pcPlus4;
    o_misalignRaw = 1'b0;
    case (i_pcSrc)
      PC_SRC_SEQ:    o_nextPc = w_pcPlus4;
      PC_SRC_BRANCH: o_nextPc = w_pcPlus4 + w_branchOffset;
      PC_SRC_REG: begin
        o_nextPc      = i_regJumpAddr & 32'hFFFF_FFFC;
        o_misalignRaw = !isWordAligned(i_regJumpAddr);
      end
      PC_SRC_JUMP:   o_nextPc = i_jumpAddr;
      default:       o_nextPc = w_pcPlus4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register with boot/run/halt sequencing, a sticky
// misaligned-register-jump flag and, when PC_PERF_CNT_EN is defined,
// a retired PC-write counter on output InstrCount.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] RegJumpAddr,
  input  logic [31:0] JumpAddr,
  input  logic        Halt,
  output logic [31:0] PC,
  output logic [31:0] PC4,
`ifdef PC_PERF_CNT_EN
  output logic [31:0] InstrCount,
`endif
  output logic        Running,
  output logic        Misaligned
);

  pc_state_t   r_state;
  logic        r_running;
  logic [31:0] r_pc;
  logic        r_misaligned;
  logic [31:0] w_nextPc;
  logic        w_misalignRaw;
  logic        w_accept;

  pc_next_mux u_nextMux (
    .i_pc          (r_pc),
    .i_pcSrc       (PCSrc),
    .i_immExt      (ImmExt),
    .i_regJumpAddr (RegJumpAddr),
    .i_jumpAddr    (JumpAddr),
    .o_nextPc      (w_nextPc),
    .o_misalignRaw (w_misalignRaw)
  );

  // A write is taken only while running, enabled, and not halting; Halt wins.
  assign w_accept = (r_state == RUN) && PCWre && !Halt;

  // Boot lasts one cycle, run until Halt, halted is left only by Reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state   <= BOOT;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state   <= RUN;
          r_running <= 1'b1;
        end
        RUN: begin
          if (Halt) begin
            r_state   <= HALTED;
            r_running <= 1'b0;
          end
        end
        HALTED: begin
          r_state   <= HALTED;
          r_running <= 1'b0;
        end
        default: begin
          r_state   <= BOOT;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // PC loads the selected next value on an accepted write; the misalign flag is sticky.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
    end else if (w_accept) begin
      r_pc <= w_nextPc;
      if (w_misalignRaw) begin
        r_misaligned <= 1'b1;
      end
    end
  end

`ifdef PC_PERF_CNT_EN
  logic [31:0] r_instrCount;

  // Count accepted PC writes; frozen outside RUN since no write is accepted there.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_instrCount <= 32'd0;
    end else if (w_accept) begin
      r_instrCount <= r_instrCount + 32'd1;
    end
  end

  assign InstrCount = r_instrCount;
`endif

  assign PC         = r_pc;
  assign PC4        = r_pc + 32'd4;
  assign Running    = r_running;
  assign Misaligned = r_misaligned;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter register and next-PC selector for the multicycle CPU. It holds the architectural PC and chooses the next value from four sources: sequential, branch, register jump, and immediate jump. The immediate-jump target arrives pre-formed from the immediate-jump address former. The block updates only when the control unit asserts the PC write enable. A small state machine handles boot after reset and a terminal halt.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- PCWre  input  1  PC write enable from the control unit.
- PCSrc  input  2  next-PC source select: 00 sequential, 01 branch, 10 register jump, 11 immediate jump.
- ImmExt  input  32  sign-extended 16-bit branch offset, in words.
- RegJumpAddr  input  32  register-jump target (rs value).
- JumpAddr  input  32  immediate-jump target {PC[31:28], imm26, 2'b00} from the jump address former.
- Halt  input  1  halt request from the decoder.
- PC  output  32  current PC, registered.
- PC4  output  32  PC + 4, combinational from PC.
- Running  output  1  high only in the RUN state.
- Misaligned  output  1  sticky flag for a non-word-aligned register-jump target.

## Operation
- States are BOOT, RUN and HALTED.
- Reset behaviour: asynchronously forces state = BOOT, PC = RESET_PC, Misaligned = 0.
  - A reset asserted mid-instruction overrides everything in the same instant.
- BOOT:
  - Lasts exactly one cycle after Reset deasserts. PCWre is ignored.
  - Always goes to RUN.
- RUN, with Halt = 1:
  - Next state is HALTED. The PC is not written, even if PCWre = 1; Halt wins.
- RUN, with Halt = 0 and PCWre = 1:
  - PC loads the selected next-PC.
  - With PCWre = 0, PC holds.
- HALTED:
  - Terminal. PC and flags hold, and all inputs are ignored.
  - Only Reset leaves this state.
- Next-PC by PCSrc, all arithmetic 32-bit modulo 2^32 with wrap silently allowed:
  - 00: PC + 4.
  - 01: PC + 4 + (ImmExt << 2), with the shift discarding the top two bits.
  - 10: {RegJumpAddr[31:2], 2'b00}. If RegJumpAddr[1:0] != 0 at the moment of the write, Misaligned is set to 1 and stays set until Reset.
  - 11: JumpAddr, used as-is.
- Misaligned is set only on an accepted write: RUN, PCWre = 1, Halt = 0, PCSrc = 10.
- PC wraps from 32'hFFFF_FFFC to 32'h0000_0000 on sequential increment. No flag is raised.

## Timing
- Reset values: PC = RESET_PC, PC4 = RESET_PC + 4, Running = 0, Misaligned = 0, InstrCount = 0.
- Write latency is 1 cycle. Next-PC is sampled on the rising edge where PCWre = 1, and PC shows it immediately after that edge.
- PC4 and the internal next-PC are combinational from the PC register and inputs. There is no registered path.
- Running rises one cycle after Reset deasserts and falls on the edge that enters HALTED.
- If PCWre is held high across consecutive RUN cycles, the PC advances every cycle.

## Configuration
- PC_PERF_CNT_EN controls the retired-write counter.
- Defined:
  - Adds output InstrCount (32 bits).
  - InstrCount increments on every accepted PC write and wraps modulo 2^32.
  - Reset clears it to 0, and it freezes in HALTED.
- Undefined:
  - The port and counter are absent; all other behaviour is identical.

## Structure
- The shared package cpu_pkg holds:
  - PCSrc encodings PC_SRC_SEQ = 2'b00, PC_SRC_BRANCH = 2'b01, PC_SRC_REG = 2'b10, PC_SRC_JUMP = 2'b11.
  - The state enum pc_state_t {BOOT, RUN, HALTED}.
- Sub-module pc_next_mux is purely combinational. It takes PC, PCSrc, ImmExt, RegJumpAddr and JumpAddr, and produces the next-PC plus a raw misalign bit.
- The top level contains the PC register, the FSM, the sticky flag and the optional counter.

## Test plan
- Reset, then sequential stepping:
  - Stimulus: assert Reset with RESET_PC = 0, release it, hold PCWre = 1 with PCSrc = 00.
  - Expected: Running = 1 one cycle after release, then PC = 0x4, 0x8, 0xC on successive edges; PC4 always equals PC + 4.
- Branch targets:
  - Backward: PC = 0x100, ImmExt = 0xFFFF_FFFE, PCSrc = 01, PCWre = 1 → PC = 0xFC.
  - Forward: ImmExt = 0x3 → PC = 0x110.
- Jumps:
  - Immediate: PCSrc = 11, JumpAddr = 0x0040_0020 → PC = 0x0040_0020.
  - Misaligned register jump: PCSrc = 10, RegJumpAddr = 0x0000_1003 → PC = 0x1000, Misaligned = 1 and still 1 after a later aligned jump.
- Halt:
  - Stimulus: Halt = 1 with PCWre = 1 and PCSrc = 00 at PC = 0x20.
  - Expected: PC stays 0x20, Running = 0, and PC is unchanged for 10 further cycles of PCWre = 1.
- Reset mid-run and wrap:
  - Reset asserted mid-cycle at PC = 0x80: PC goes to RESET_PC asynchronously, before the next edge.
  - Wrap: PC = 0xFFFF_FFFC with PCSrc = 00 → PC = 0x0.
- Counter (PC_PERF_CNT_EN defined):
  - Stimulus: 5 accepted writes, 3 cycles with PCWre = 0, then Halt.
  - Expected: InstrCount = 5 and holds 5 in HALTED.
